// File: rtl/jk_mod_counter_pkg.sv
// Shared sequential-circuit definitions: direction encoding and default sizing.
package jk_mod_counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 10;
endpackage

// File: rtl/jk_mod_counter_jkff.sv
// Single JK flip-flop with asynchronous active-high reset.
module jkff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);
  logic q_q, q_d;

  // JK characteristic: hold / clear / set / toggle
  always_comb begin
    q_d = q_q;
    case ({j, k})
      2'b00: q_d = q_q;
      2'b01: q_d = 1'b0;
      2'b10: q_d = 1'b1;
      2'b11: q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // state register, reset forces q low regardless of clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q  = q_q;
  assign qb = ~q_q;
endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from per-bit JK flip-flops, with
// parallel load (clamped to range), terminal count, wrap and load-error pulses.
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);
  // MODULUS may equal 2**WIDTH, so range compares need one extra bit
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j, k;
  logic [WIDTH-1:0] qb_unused;
  logic             din_ok;
  logic             at_max, at_zero;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  assign din_ok  = ({1'b0, din} < MOD_EXT);
  assign at_max  = (count == MAX_CNT);
  assign at_zero = (count == '0);

  // terminal count: an enabled, non-loading step that will wrap
  assign tc = en & ~load & ((up & at_max) | (~up & at_zero));

  // target value for this edge; excitation only drives bits that must change,
  // so unchanged bits (including the whole word on hold) see J=K=0
  always_comb begin
    nxt        = count;
    load_err_d = 1'b0;
    wrap_d     = 1'b0;
    if (load) begin
      nxt        = din_ok ? din : MAX_CNT;
      load_err_d = ~din_ok;
    end else if (en) begin
      wrap_d = tc;
      if (up == DIR_UP) nxt = at_max  ? '0      : count + WIDTH'(1);
      else              nxt = at_zero ? MAX_CNT : count - WIDTH'(1);
    end
    j = ~count & nxt;
    k =  count & ~nxt;
  end

  // per-bit storage
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jkff u_ff (
      .clk (clk),
      .rst (rst),
      .j   (j[i]),
      .k   (k[i]),
      .q   (count[i]),
      .qb  (qb_unused[i])
    );
  end

  // one-cycle status pulses, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter (WIDTH=4, MODULUS=10): directed
// scenarios followed by random traffic, all checked against an arithmetic model.
module tb_jk_mod_counter;
  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0, up = 1'b0, load = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] count;
  logic         tc, wrap, load_err;

  int n_chk = 0;
  int n_err = 0;
  int m     = 0;   // model count

  jk_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .count(count), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, check tc before the edge and state after it
  task automatic step(input logic l, input logic e, input logic u, input int d);
    int  exp_tc, exp_wrap, exp_lerr;
    load = l; en = e; up = u; din = W'(d);
    #1;
    exp_tc = (e && !l && ((u && m == MOD-1) || (!u && m == 0))) ? 1 : 0;
    chk("tc", int'(tc), exp_tc);
    exp_wrap = exp_tc;
    exp_lerr = 0;
    if (l) begin
      if (d < MOD) m = d;
      else begin m = MOD-1; exp_lerr = 1; end
    end else if (e) begin
      m = u ? (m + 1) % MOD : (m + MOD - 1) % MOD;
    end
    @(posedge clk); #1;
    chk("count", int'(count), m);
    chk("wrap", int'(wrap), exp_wrap);
    chk("load_err", int'(load_err), exp_lerr);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_count", int'(count), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_lerr", int'(load_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m = 0;

    // count up 12 cycles: 1..9,0,1,2
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 0);
    chk("up12_final", int'(count), 2);

    // load 0 then count down: 9,8,7
    step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 0);
    chk("dn3_final", int'(count), 7);

    // out-of-range load clamps, then load beats enable at max
    step(1'b1, 1'b0, 1'b0, 13);
    step(1'b0, 1'b0, 1'b0, 0);            // load_err must drop
    step(1'b1, 1'b0, 1'b0, 9);
    step(1'b1, 1'b1, 1'b1, 5);            // would wrap if en won
    chk("load_wins", int'(count), 5);

    // hold with direction toggling
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, i[0], 0);

    // count to 6, then reset between edges
    step(1'b1, 1'b0, 1'b0, 4);
    step(1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 0);
    chk("pre_rst", int'(count), 6);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_wrap", int'(wrap), 0);
    chk("async_rst_lerr", int'(load_err), 0);
    m = 0;
    // inputs ignored while reset is held
    load = 1'b1; din = 4'd15; en = 1'b1; up = 1'b0;
    @(posedge clk); #1;
    chk("rst_hold_count", int'(count), 0);
    chk("rst_hold_lerr", int'(load_err), 0);
    chk("rst_hold_wrap", int'(wrap), 0);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b1, 0);
    chk("resume", int'(count), 1);

    // direction change at 9: 9 -> 8 (no wrap) -> 9
    step(1'b1, 1'b0, 1'b0, 9);
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 0);
    chk("dir_swap", int'(count), 9);

    // reset while the wrap pulse is high clears it immediately
    step(1'b0, 1'b1, 1'b1, 0);
    chk("wrap_before_rst", int'(wrap), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_kills_wrap", int'(wrap), 0);
    load = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m = 0;

    // random traffic
    for (int i = 0; i < 300; i++) begin
      logic l, e, u;
      int   d;
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = 1'($urandom);
      d = int'($urandom_range(0, 15));
      step(l, e, u, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // hard stop guard
  initial begin
    #200000;
    $display("FAIL timeout count=%0d expected=finished", count);
    $fatal(1, "timeout");
  end
endmodule
